// File: rtl/fpmul_stream_pkg.sv
// Shared types and default parameters for the streaming FP multiplier wrapper.
package fpmul_stream_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_TAG_W      = 4;
  localparam int unsigned DEF_PIPE_LAT   = 4;
  localparam int unsigned DEF_FIFO_DEPTH = 8;
  localparam int unsigned DEF_CNT_W      = 32;

  // Output buffer must hold every credit-admitted beat and wrap on a power of two.
  function automatic bit cfg_ok(input int unsigned depth, input int unsigned lat);
    return (depth >= lat) && (depth != 0) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/FPmul.sv
// Four-stage IEEE-754 single-precision multiplier core (RNE, subnormals flushed to zero).
module FPmul (
  input  logic        clk,
  input  logic        RST_n,
  input  logic        VIN,
  input  logic [31:0] FP_A,
  input  logic [31:0] FP_B,
  output logic [31:0] FP_Z,
  output logic        VOUT
);

  typedef enum logic [1:0] {CLS_NUM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

  logic [7:0]        w_ea, w_eb;
  logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_nan;
  cls_t              w_cls;
  logic              r1_sign, r2_sign, r3_sign;
  logic signed [9:0] r1_exp, r2_exp, r3_exp, w_norm_exp;
  logic [23:0]       r1_ma, r1_mb;
  cls_t              r1_cls, r2_cls, r3_cls;
  logic [47:0]       r2_prod;
  logic [22:0]       w_frac, r3_frac;
  logic              w_guard, w_sticky, w_rnd;
  logic [23:0]       w_frac_rnd;
  logic [31:0]       w_z;
  logic [3:0]        r_vout;

  // Operand classification for special-value handling.
  always_comb begin
    w_ea     = FP_A[30:23];
    w_eb     = FP_B[30:23];
    w_a_zero = (w_ea == 8'd0);
    w_b_zero = (w_eb == 8'd0);
    w_a_inf  = (w_ea == 8'hFF) && (FP_A[22:0] == 23'd0);
    w_b_inf  = (w_eb == 8'hFF) && (FP_B[22:0] == 23'd0);
    w_nan    = ((w_ea == 8'hFF) && (FP_A[22:0] != 23'd0)) ||
               ((w_eb == 8'hFF) && (FP_B[22:0] != 23'd0)) ||
               (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero);
    w_cls    = CLS_NUM;
    if (w_nan)                  w_cls = CLS_NAN;
    else if (w_a_inf || w_b_inf) w_cls = CLS_INF;
    else if (w_a_zero || w_b_zero) w_cls = CLS_ZERO;
  end

  // Normalise the mantissa product and round to nearest even.
  always_comb begin
    w_norm_exp = r2_exp;
    w_frac     = r2_prod[45:23];
    w_guard    = r2_prod[22];
    w_sticky   = |r2_prod[21:0];
    if (r2_prod[47]) begin
      w_frac     = r2_prod[46:24];
      w_guard    = r2_prod[23];
      w_sticky   = |r2_prod[22:0];
      w_norm_exp = r2_exp + 10'sd1;
    end
    w_rnd      = w_guard & (w_sticky | w_frac[0]);
    w_frac_rnd = 24'(w_frac) + 24'(w_rnd);
    if (w_frac_rnd[23]) w_norm_exp = w_norm_exp + 10'sd1;
  end

  // Final packing with overflow to infinity and underflow to signed zero.
  always_comb begin
    w_z = {r3_sign, r3_exp[7:0], r3_frac};
    case (r3_cls)
      CLS_NAN:  w_z = 32'h7FC0_0000;
      CLS_INF:  w_z = {r3_sign, 8'hFF, 23'd0};
      CLS_ZERO: w_z = {r3_sign, 31'd0};
      default: begin
        if (r3_exp >= 10'sd255)    w_z = {r3_sign, 8'hFF, 23'd0};
        else if (r3_exp <= 10'sd0) w_z = {r3_sign, 31'd0};
      end
    endcase
  end

  // Pipeline registers: unpack, multiply, round, pack.
  always_ff @(posedge clk) begin
    if (!RST_n) begin
      r1_sign <= 1'b0; r1_exp <= '0; r1_ma <= '0; r1_mb <= '0; r1_cls <= CLS_ZERO;
      r2_sign <= 1'b0; r2_exp <= '0; r2_prod <= '0; r2_cls <= CLS_ZERO;
      r3_sign <= 1'b0; r3_exp <= '0; r3_frac <= '0; r3_cls <= CLS_ZERO;
      FP_Z    <= '0;
      r_vout  <= '0;
    end else begin
      r1_sign <= FP_A[31] ^ FP_B[31];
      r1_exp  <= 10'(w_ea) + 10'(w_eb) - 10'sd127;
      r1_ma   <= {1'b1, FP_A[22:0]};
      r1_mb   <= {1'b1, FP_B[22:0]};
      r1_cls  <= w_cls;
      r2_sign <= r1_sign;
      r2_exp  <= r1_exp;
      r2_prod <= 48'(r1_ma) * 48'(r1_mb);
      r2_cls  <= r1_cls;
      r3_sign <= r2_sign;
      r3_exp  <= w_norm_exp;
      r3_frac <= w_frac_rnd[22:0];
      r3_cls  <= r2_cls;
      FP_Z    <= w_z;
      r_vout  <= {r_vout[2:0], VIN};
    end
  end

  assign VOUT = r_vout[3];

endmodule

// File: rtl/fpmul_stream_fifo.sv
// Synchronous data+tag FIFO with occupancy count and push-drop indication.
module fpmul_stream_fifo #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned TAG_W  = 4,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic [TAG_W-1:0]  o_tag,
  output logic [CW-1:0]     o_count,
  output logic              o_drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [TAG_W-1:0]  r_mem_tag  [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_pop, w_full, w_wr;

  assign w_pop    = i_pop && (r_count != '0);
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_wr     = i_push && (!w_full || w_pop);
  assign o_drop_c = i_push && w_full && !w_pop;
  assign o_data   = r_mem_data[r_rd_ptr];
  assign o_tag    = r_mem_tag[r_rd_ptr];
  assign o_count  = r_count;

  // Storage, pointers and count; a pop on full frees the slot the push takes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem_data[i] <= '0;
        r_mem_tag[i]  <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem_data[r_wr_ptr] <= i_data;
        r_mem_tag[r_wr_ptr]  <= i_tag;
        r_wr_ptr             <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fpmul_stream.sv
// Streaming valid/ready wrapper around FPmul with tag sideband and credit-based output buffering.
module fpmul_stream
  import fpmul_stream_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned TAG_W      = DEF_TAG_W,
  parameter int unsigned PIPE_LAT   = DEF_PIPE_LAT,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [CNT_W-1:0]  acc_count,
  output logic [CNT_W-1:0]  ret_count,
  output logic              ovf_err
);

  localparam int unsigned FCW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + PIPE_LAT + 1);

  if (!cfg_ok(FIFO_DEPTH, PIPE_LAT)) begin : g_cfg_err
    $error("fpmul_stream: FIFO_DEPTH must be a power of two and >= PIPE_LAT");
  end

  state_t             r_state, w_state_nxt;
  logic [PIPE_LAT-1:0] r_vld;
  logic [TAG_W-1:0]   r_tag_pipe [PIPE_LAT];
  logic [OCC_W-1:0]   w_inflight, w_occ;
  logic [FCW-1:0]     w_fifo_count;
  logic [DATA_W-1:0]  w_core_z;
  logic               w_accept, w_push, w_pop, w_drop, w_rst_n, w_vout_unused;

  assign w_rst_n   = ~rst;
  assign w_accept  = in_valid && in_ready;
  assign w_push    = r_vld[PIPE_LAT-1];
  assign out_valid = (w_fifo_count != '0);
  assign w_pop     = out_valid && out_ready;

  FPmul u_core (
    .clk   (clk),
    .RST_n (w_rst_n),
    .VIN   (1'b1),
    .FP_A  (in_a),
    .FP_B  (in_b),
    .FP_Z  (w_core_z),
    .VOUT  (w_vout_unused)
  );

  fpmul_stream_fifo #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_push   (w_push),
    .i_data   (w_core_z),
    .i_tag    (r_tag_pipe[PIPE_LAT-1]),
    .i_pop    (w_pop),
    .o_data   (out_data),
    .o_tag    (out_tag),
    .o_count  (w_fifo_count),
    .o_drop_c (w_drop)
  );

  // Beats still inside the core pipeline, counted against buffer credit.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < int'(PIPE_LAT); i++) w_inflight = w_inflight + OCC_W'(r_vld[i]);
    w_occ = OCC_W'(w_fifo_count) + w_inflight;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= INIT;
    else     r_state <= w_state_nxt;
  end

  // Next state and input-side ready; a same-cycle pop does not free credit.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      INIT:    w_state_nxt = RUN;
      RUN:     in_ready    = (w_occ < OCC_W'(FIFO_DEPTH));
      default: w_state_nxt = INIT;
    endcase
  end

  // Valid/tag shift register running alongside the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < int'(PIPE_LAT); i++) r_tag_pipe[i] <= '0;
    end else begin
      r_vld         <= {r_vld[PIPE_LAT-2:0], w_accept};
      r_tag_pipe[0] <= in_tag;
      for (int i = 1; i < int'(PIPE_LAT); i++) r_tag_pipe[i] <= r_tag_pipe[i-1];
    end
  end

  // Transaction counters and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_count <= '0;
      ret_count <= '0;
      ovf_err   <= 1'b0;
    end else begin
      acc_count <= acc_count + CNT_W'(w_accept);
      ret_count <= ret_count + CNT_W'(w_pop);
      if (w_drop) ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpmul_stream.sv
// Directed and randomised checks of fpmul_stream ordering, latency, credit and reset.
module tb_fpmul_stream;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, ovf_err;
  logic [31:0] in_a, in_b, out_data, acc_count, ret_count;
  logic [3:0]  in_tag, out_tag;

  always #5 clk = ~clk;

  fpmul_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .acc_count (acc_count),
    .ret_count (ret_count),
    .ovf_err   (ovf_err)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          first_pop, last_pop;
  logic        last_acc;
  logic [31:0] exp_val;
  logic [35:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Exact float of a small positive integer.
  function automatic logic [31:0] int_to_fp(input int unsigned n);
    int e = 0;
    for (int i = 0; i < 32; i++) if ((n >> i) != 0) e = i;
    return {1'b0, 8'(127 + e), 23'(n << (23 - e))};
  endfunction

  function automatic logic [63:0] f2d(input logic [31:0] f);
    return {f[31], 11'(32'(f[30:23]) + 32'd896), f[22:0], 29'd0};
  endfunction

  // Reference product: exact double multiply, then round-to-nearest-even to single.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    real         p;
    logic [63:0] d;
    logic [23:0] m;
    int          e;
    p = $bitstoreal(f2d(a)) * $bitstoreal(f2d(b));
    d = $realtobits(p);
    e = int'(d[62:52]) - 896;
    m = {1'b0, d[51:29]} + 24'(d[28] & ((|d[27:0]) | d[29]));
    if (m[23]) e++;
    return {d[63], 8'(e), m[22:0]};
  endfunction

  // One clock: log accepted beats, score delivered beats, then advance.
  task automatic cycle();
    logic [35:0] e;
    last_acc = in_valid && in_ready;
    if (last_acc) exp_q.push_back({in_tag, exp_val});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (e[30:23] == 8'hFF && e[22:0] != 23'd0)
          check("out_nan", 32'(out_data[30:23] == 8'hFF && out_data[22:0] != 23'd0), 32'd1);
        else
          check("out_data", out_data, e[31:0]);
        check("out_tag", 32'(out_tag), 32'(e[35:32]));
      end
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                      input logic [31:0] e, output int acc_cyc);
    int g = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = t; exp_val = e;
    acc_cyc = cyc;
    do begin
      acc_cyc = cyc;
      cycle();
      g++;
    end while (!last_acc && g < 200);
    if (!last_acc) check("send_timeout", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && g < 300) begin
      cycle();
      g++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_beat(input logic [31:0] a, input int unsigned k, input int unsigned mul);
    in_a = a; in_b = int_to_fp(k + 1); in_tag = 4'(k); exp_val = int_to_fp(mul * (k + 1));
  endtask

  initial begin
    int   a0, a, k, g, n, c_start;
    logic saw;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b0; exp_val = '0; last_acc = 1'b0; first_pop = -1; last_pop = -1;
    #1;
    repeat (3) cycle();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_acc_count", acc_count, 32'd0);
    check("rst_ret_count", ret_count, 32'd0);
    check("rst_ovf_err", 32'(ovf_err), 32'd0);
    rst = 1'b0;
    check("post_rst_cyc1_ready", 32'(in_ready), 32'd0);
    cycle();
    check("post_rst_cyc2_ready", 32'(in_ready), 32'd1);

    // Back-to-back: 2.0 * (k+1)
    out_ready = 1'b1; first_pop = -1; c_start = cyc; a0 = 0;
    for (int i = 0; i < 16; i++) begin
      send(32'h4000_0000, int_to_fp(i + 1), 4'(i), int_to_fp(2 * (i + 1)), a);
      if (i == 0) a0 = a;
    end
    check("b2b_accept_cycles", 32'(cyc - c_start), 32'd16);
    drain();
    check("b2b_first_latency", 32'(first_pop - a0), 32'd5);
    check("b2b_out_spacing", 32'(last_pop - first_pop), 32'd15);
    check("b2b_acc_count", acc_count, 32'd16);
    check("b2b_ret_count", ret_count, 32'd16);

    // Back-pressure: 4.0 * (k+1), consumer stalled
    out_ready = 1'b0; k = 0; in_valid = 1'b1;
    set_beat(32'h4080_0000, k, 4);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_acc) begin k++; set_beat(32'h4080_0000, k, 4); end
    end
    check("bp_acc_count", acc_count, 32'd24);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_ovf_err", 32'(ovf_err), 32'd0);
    out_ready = 1'b1;
    check("bp_no_bypass", 32'(in_ready), 32'd0);
    g = 0;
    while (k < 12 && g < 100) begin
      cycle();
      if (last_acc) begin k++; set_beat(32'h4080_0000, k, 4); end
      g++;
    end
    in_valid = 1'b0;
    drain();
    check("bp_acc_resumed", acc_count, 32'd28);
    check("bp_ret_count", ret_count, 32'd28);

    // Special values
    send(32'h7F80_0000, 32'h0000_0000, 4'd5, 32'h7FC0_0000, a);
    send(32'h3F80_0000, 32'hBF80_0000, 4'd10, 32'hBF80_0000, a);
    send(32'h7F80_0000, 32'h4000_0000, 4'd3, 32'h7F80_0000, a);
    drain();

    // Reset with 5 buffered and 3 in flight
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_beat(32'h4040_0000, i, 3);
      send(in_a, in_b, in_tag, exp_val, a);
    end
    repeat (5) cycle();
    check("mid_buffered_valid", 32'(out_valid), 32'd1);
    for (int i = 5; i < 8; i++) begin
      set_beat(32'h4040_0000, i, 3);
      send(in_a, in_b, in_tag, exp_val, a);
    end
    rst = 1'b1;
    cycle();
    exp_q.delete();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_acc_count", acc_count, 32'd0);
    check("mid_rst_ret_count", ret_count, 32'd0);
    rst = 1'b0; out_ready = 1'b1; saw = 1'b0;
    repeat (10) begin
      if (out_valid) saw = 1'b1;
      cycle();
    end
    check("mid_rst_no_output", 32'(saw), 32'd0);
    send(32'h4000_0000, 32'h4040_0000, 4'd7, 32'h40C0_0000, a);
    g = 0;
    while (!out_valid && g < 50) begin cycle(); g++; end
    check("mid_rst_latency", 32'(cyc - a), 32'd5);
    drain();

    // Random valid/ready traffic against the reference model
    n = 0; g = 0; in_valid = 1'b0;
    while (n < 1000 && g < 20000) begin
      if (!in_valid && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        in_a     = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
        in_b     = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
        in_tag   = 4'($urandom);
        exp_val  = ref_mul(in_a, in_b);
      end
      out_ready = 1'($urandom_range(0, 1));
      cycle();
      g++;
      if (last_acc) begin n++; in_valid = 1'b0; end
    end
    in_valid = 1'b0;
    check("rnd_beats", 32'(n), 32'd1000);
    drain();
    check("rnd_acc_count", acc_count, 32'd1001);
    check("rnd_ret_count", ret_count, 32'd1001);
    check("rnd_ovf_err", 32'(ovf_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
